// File: rtl/key_latch_driver_pkg.sv
// Shared constants and helpers for the key-to-latch front end.
package key_latch_driver_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;

  // Debounce window in clock cycles for a given number of milliseconds.
  function automatic int unsigned ms_to_cycles(input int unsigned ms,
                                               input int unsigned clk_hz = CLK_HZ);
    return (clk_hz / 1000) * ms;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, with selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // NOTE: async reset in the sensitivity list, and <= so both flops sample
  // the pre-edge values and the chain really is two stages deep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RST_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/key_latch_driver.sv
// Debounces a pushbutton and drives a gated latch: D is captured on press,
// then EN strobes for EN_CYCLES while D stays frozen.
module key_latch_driver
  import key_latch_driver_pkg::*;
#(
  parameter int unsigned DB_CYCLES = ms_to_cycles(20),
  parameter int unsigned EN_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic KEY_n,
  input  logic SW,
  output logic D,
  output logic EN,
  output logic BUSY
);

  localparam int unsigned CNT_TOP = max_u(DB_CYCLES, EN_CYCLES);
  localparam int          CNT_W   = $clog2(CNT_TOP + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  // PRESS_DB/REL_DB enter with the first sample already counted.
  localparam cnt_t DB_LAST = cnt_t'(DB_CYCLES - 1);
  localparam cnt_t EN_LAST = cnt_t'(EN_CYCLES);
  localparam cnt_t CNT_ONE = cnt_t'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    SETUP    = 3'd2,
    STROBE   = 3'd3,
    WAIT_REL = 3'd4,
    REL_DB   = 3'd5
  } state_e;

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d, cnt_inc;
  logic   d_q, d_d;
  logic   en_q, busy_q;
  logic   key_sync, sw_sync;

  sync_2ff #(.RST_VAL(1'b1)) u_key_sync (
    .clk   (CLK),
    .rst_n (RST_n),
    .d_i   (KEY_n),
    .q_o   (key_sync)
  );

  sync_2ff #(.RST_VAL(1'b0)) u_sw_sync (
    .clk   (CLK),
    .rst_n (RST_n),
    .d_i   (SW),
    .q_o   (sw_sync)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    case (state_q)
      IDLE: begin
        if (!key_sync) begin
          state_d = PRESS_DB;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_DB: begin
        if (key_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          d_d     = sw_sync;
          state_d = SETUP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = CNT_ONE;
      end
      STROBE: begin
        // Key bounce is deliberately ignored here; the strobe always completes.
        if (cnt_q >= EN_LAST) begin
          state_d = WAIT_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_REL: begin
        if (key_sync) begin
          state_d = REL_DB;
          cnt_d   = CNT_ONE;
        end
      end
      REL_DB: begin
        if (!key_sync) begin
          state_d = WAIT_REL;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      // Registered from next state so EN/BUSY line up exactly with state_q.
      en_q    <= (state_d == STROBE);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign D    = d_q;
  assign EN   = en_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_key_latch_driver.sv
// Directed bench for key_latch_driver with DB_CYCLES=4, EN_CYCLES=3.
module tb_key_latch_driver;

  localparam int DB  = 4;
  localparam int ENC = 3;

  logic CLK = 1'b0;
  logic RST_n;
  logic KEY_n;
  logic SW;
  logic D;
  logic EN;
  logic BUSY;

  int   n_pass  = 0;
  int   n_total = 0;
  bit   exp_q[$];
  logic prev_en  = 1'b0;
  int   en_width = 0;
  logic d_hold   = 1'b0;
  int   strobes  = 0;
  logic exp_d    = 1'b0;

  always #5 CLK = ~CLK;

  key_latch_driver #(
    .DB_CYCLES (DB),
    .EN_CYCLES (ENC)
  ) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .KEY_n (KEY_n),
    .SW    (SW),
    .D     (D),
    .EN    (EN),
    .BUSY  (BUSY)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Strobe monitor: pops the expected D at each EN rise, checks width and D stability.
  task automatic monitor();
    if (EN === 1'b1 && !prev_en) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("strobe_d", D, exp_q.pop_front());
      en_width = 1;
      d_hold   = D;
    end else if (EN === 1'b1) begin
      en_width++;
      check("d_stable_en", D, d_hold);
    end else if (prev_en) begin
      check("en_width", en_width, ENC);
      strobes++;
    end
    prev_en = (EN === 1'b1);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    monitor();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && BUSY !== 1'b0; i++) tick();
    check("idle_reached", BUSY, 0);
  endtask

  initial begin
    RST_n = 1'b0;
    KEY_n = 1'b1;
    SW    = 1'b0;
    #1;
    check("rst_d", D, 0);
    check("rst_en", EN, 0);
    check("rst_busy", BUSY, 0);
    ticks(2);
    RST_n = 1'b1;
    ticks(3);
    check("idle_busy", BUSY, 0);

    // Clean press with SW=1; KEY_n driven low just after edge 0.
    SW = 1'b1;
    ticks(3);
    KEY_n = 1'b0;
    exp_q.push_back(1'b1);
    exp_d = 1'b1;
    ticks(2);
    check("t1_busy_e2", BUSY, 0);
    tick();
    check("t1_busy_e3", BUSY, 1);
    ticks(2);
    check("t1_d_e5", D, 0);
    tick();
    check("t1_d_e6", D, 1);
    check("t1_en_e6", EN, 0);
    tick();
    check("t1_en_e7", EN, 1);
    ticks(2);
    check("t1_en_e9", EN, 1);
    tick();
    check("t1_en_e10", EN, 0);
    check("t1_strobes", strobes, 1);
    KEY_n = 1'b1;
    wait_idle();

    // Bounce: low 2 cycles, high 1, then low held (last low driven after edge 3).
    SW = 1'b0;
    ticks(3);
    KEY_n = 1'b0;
    exp_q.push_back(1'b0);
    ticks(2);
    KEY_n = 1'b1;
    tick();
    KEY_n = 1'b0;
    check("t2_busy_e3", BUSY, 1);
    ticks(2);
    check("t2_busy_rejected", BUSY, 0);
    check("t2_d_rejected", D, exp_d);
    ticks(3);
    check("t2_d_e8", D, exp_d);
    check("t2_en_e8", EN, 0);
    tick();
    exp_d = 1'b0;
    check("t2_d_e9", D, exp_d);
    check("t2_en_e9", EN, 0);
    tick();
    check("t2_en_e10", EN, 1);
    ticks(3);
    check("t2_en_e13", EN, 0);
    check("t2_strobes", strobes, 2);
    KEY_n = 1'b1;
    wait_idle();

    // Hold for 50 cycles with SW toggling; value driven after edge 3 is captured.
    ticks(3);
    KEY_n = 1'b0;
    for (int i = 0; i < 50; i++) begin
      SW = (i % 2 == 1);
      if (i == 3) begin
        exp_q.push_back(SW);
        exp_d = SW;
      end
      tick();
    end
    check("t3_strobes", strobes, 3);
    check("t3_en", EN, 0);
    check("t3_busy_held", BUSY, 1);
    check("t3_d", D, exp_d);

    // Release bounce, then stable high from edge R.
    for (int i = 0; i < 8; i++) begin
      KEY_n = (i % 2 == 0);
      tick();
    end
    KEY_n = 1'b1;
    SW    = ~exp_d;
    ticks(5);
    check("t4_busy_r5", BUSY, 1);
    tick();
    check("t4_busy_r6", BUSY, 0);
    ticks(2);
    KEY_n = 1'b0;
    exp_q.push_back(SW);
    exp_d = SW;
    ticks(10);
    check("t4_strobes", strobes, 4);
    check("t4_d", D, exp_d);
    KEY_n = 1'b1;
    wait_idle();

    // Reset mid-STROBE with key held low, then full debounce again.
    SW = ~exp_d;
    ticks(3);
    KEY_n = 1'b0;
    exp_q.push_back(SW);
    ticks(8);
    check("t5_en_mid", EN, 1);
    RST_n = 1'b0;
    #1;
    check("t5_rst_d", D, 0);
    check("t5_rst_en", EN, 0);
    check("t5_rst_busy", BUSY, 0);
    prev_en  = 1'b0;
    en_width = 0;
    ticks(2);
    RST_n = 1'b1;
    exp_q.push_back(SW);
    exp_d = SW;
    ticks(2);
    check("t5_busy_e2", BUSY, 0);
    ticks(3);
    check("t5_d_e5", D, 0);
    check("t5_busy_e5", BUSY, 1);
    tick();
    check("t5_d_e6", D, exp_d);
    tick();
    check("t5_en_e7", EN, 1);
    ticks(3);
    check("t5_en_e10", EN, 0);
    check("t5_strobes", strobes, 5);
    KEY_n = 1'b1;
    wait_idle();

    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
